// File: rtl/hdmi_audio_pkg.sv
// Shared types and defaults for the HDMI audio pacing block.
// Used by hdmi_audio_scheduler and audio_frame_fifo.
package hdmi_audio_pkg;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } audio_state_t;

    typedef struct packed {
        logic signed [15:0] l;
        logic signed [15:0] r;
    } stereo_t;

    localparam int AUDIO_ADD_DEFAULT = 8;
    localparam int AUDIO_MAX_DEFAULT = 3125;
    localparam int PCM_W             = 24;

    // hdmi_tx expects 24-bit samples: sign-extend to 19 bits, pad 5 LSBs with zero.
    function automatic logic [PCM_W-1:0] pcm_format(input logic signed [15:0] s);
        return {{3{s[15]}}, s, 5'b0};
    endfunction

endpackage

// File: rtl/audio_frame_fifo.sv
// Single-clock FIFO of stereo frames; dout is the head word, level/full/empty come straight off the pointers.
// A push while full is taken only when a pop happens in the same cycle; a pop while empty is ignored.
module audio_frame_fifo
    import hdmi_audio_pkg::*;
#(
    parameter int FIFO_AW = 3
) (
    input  logic             pixel_clk,
    input  logic             sys_reset_125,
    input  logic             push,
    input  logic             pop,
    input  stereo_t          din,
    output stereo_t          dout,
    output logic             full,
    output logic             empty,
    output logic [FIFO_AW:0] level
);

    localparam int DEPTH = 1 << FIFO_AW;

    stereo_t          mem_q [DEPTH];
    logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Equal indices with differing wrap bits means the writer is one lap ahead.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                   (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;
    assign dout  = mem_q[rd_ptr_q[FIFO_AW-1:0]];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge pixel_clk or posedge sys_reset_125) begin
        if (sys_reset_125) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[FIFO_AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/hdmi_audio_scheduler.sv
// Paces buffered stereo PCM into hdmi_tx at 32 kHz from pixel_clk; pcm_l/pcm_r change only on pcm_fs falling slots.
// Producer stalls on in_ready (8-frame FIFO); define HDMI_AUDIO_SOFT_MUTE_EN for a 16-slot mute gain ramp.
module hdmi_audio_scheduler
    import hdmi_audio_pkg::*;
#(
    parameter int COUNT_WIDTH = 13,
    parameter int ADD         = AUDIO_ADD_DEFAULT,
    parameter int MAX         = AUDIO_MAX_DEFAULT,
    parameter int FIFO_AW     = 3,
    parameter int PRIME_LEVEL = 4
) (
    input  logic             pixel_clk,
    input  logic             sys_reset_125,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_left,
    input  logic [15:0]      in_right,
    input  logic             mute,
    output logic             pcm_fs,
    output logic [PCM_W-1:0] pcm_l,
    output logic [PCM_W-1:0] pcm_r,
    output logic [FIFO_AW:0] fifo_level,
    output logic [15:0]      underrun_cnt,
    output logic [15:0]      overflow_cnt
);

    localparam logic [FIFO_AW:0] PRIME_THRESH = (FIFO_AW+1)'(PRIME_LEVEL);

    logic [COUNT_WIDTH-1:0] count_q, count_d, count_sa;
    logic                   tick, slot;
    logic                   pcm_fs_q, pcm_fs_d;
    audio_state_t           state_q, state_d;
    logic [PCM_W-1:0]       pcm_l_q, pcm_l_d;
    logic [PCM_W-1:0]       pcm_r_q, pcm_r_d;
    logic [PCM_W-1:0]       load_l, load_r;
    logic [15:0]            under_q, under_d;
    logic [15:0]            over_q, over_d;
    logic                   under_inc, over_inc, accept;
    logic                   fifo_pop, fifo_full, fifo_empty;
    stereo_t                fifo_din, fifo_dout;

    // A non-negative count - MAX means the phase has wrapped: fire a tick and carry the remainder.
    always_comb begin
        count_sa = count_q - COUNT_WIDTH'(MAX);
        tick     = !count_sa[COUNT_WIDTH-1];
        count_d  = tick ? count_sa + COUNT_WIDTH'(ADD) : count_q + COUNT_WIDTH'(ADD);
    end

    assign pcm_fs_d = pcm_fs_q ^ tick;
    assign slot     = tick && pcm_fs_q;

    assign fifo_din.l = in_left;
    assign fifo_din.r = in_right;

    audio_frame_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .pixel_clk     (pixel_clk),
        .sys_reset_125 (sys_reset_125),
        .push          (in_valid),
        .pop           (fifo_pop),
        .din           (fifo_din),
        .dout          (fifo_dout),
        .full          (fifo_full),
        .empty         (fifo_empty),
        .level         (fifo_level)
    );

    assign accept   = in_valid && (!fifo_full || fifo_pop);
    assign over_inc = in_valid && !accept;

`ifdef HDMI_AUDIO_SOFT_MUTE_EN
    localparam logic [4:0] GAIN_UNITY = 5'd16;

    logic [4:0] gain_q, gain_base, gain_step;

    function automatic logic signed [15:0] apply_gain(input logic signed [15:0] s,
                                                      input logic [4:0]         g);
        logic signed [21:0] prod;
        prod = $signed({{6{s[15]}}, s}) * $signed({17'b0, g});
        return prod[19:4];
    endfunction

    // Gain restarts from zero whenever playback (re)enters RUN.
    always_comb begin
        gain_base = (state_q == RUN) ? gain_q : 5'd0;
        if (mute) begin
            gain_step = (gain_base == 5'd0) ? 5'd0 : gain_base - 5'd1;
        end else begin
            gain_step = (gain_base >= GAIN_UNITY) ? GAIN_UNITY : gain_base + 5'd1;
        end
        load_l = pcm_format(apply_gain(fifo_dout.l, gain_step));
        load_r = pcm_format(apply_gain(fifo_dout.r, gain_step));
    end

    always_ff @(posedge pixel_clk or posedge sys_reset_125) begin
        if (sys_reset_125) begin
            gain_q <= '0;
        end else if (fifo_pop) begin
            gain_q <= gain_step;
        end
    end
`else
    always_comb begin
        load_l = mute ? '0 : pcm_format(fifo_dout.l);
        load_r = mute ? '0 : pcm_format(fifo_dout.r);
    end
`endif

    always_comb begin
        state_d   = state_q;
        fifo_pop  = 1'b0;
        pcm_l_d   = pcm_l_q;
        pcm_r_d   = pcm_r_q;
        under_inc = 1'b0;
        if (slot) begin
            case (state_q)
                PRIME: begin
                    if (fifo_level >= PRIME_THRESH) begin
                        fifo_pop = 1'b1;
                        state_d  = RUN;
                        pcm_l_d  = load_l;
                        pcm_r_d  = load_r;
                    end else begin
                        pcm_l_d = '0;
                        pcm_r_d = '0;
                    end
                end
                RUN: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        pcm_l_d  = load_l;
                        pcm_r_d  = load_r;
                    end else begin
                        // Starved slot: hold the last sample so the sink sees no step, then re-prime.
                        state_d = PRIME;
                        if (mute) begin
                            pcm_l_d = '0;
                            pcm_r_d = '0;
                        end else begin
                            under_inc = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        under_d = (under_inc && (under_q != 16'hFFFF)) ? under_q + 16'd1 : under_q;
        over_d  = (over_inc  && (over_q  != 16'hFFFF)) ? over_q  + 16'd1 : over_q;
    end

    always_ff @(posedge pixel_clk or posedge sys_reset_125) begin
        if (sys_reset_125) begin
            count_q  <= '0;
            pcm_fs_q <= 1'b0;
            state_q  <= PRIME;
            pcm_l_q  <= '0;
            pcm_r_q  <= '0;
            under_q  <= '0;
            over_q   <= '0;
        end else begin
            count_q  <= count_d;
            pcm_fs_q <= pcm_fs_d;
            state_q  <= state_d;
            pcm_l_q  <= pcm_l_d;
            pcm_r_q  <= pcm_r_d;
            under_q  <= under_d;
            over_q   <= over_d;
        end
    end

    assign in_ready     = !fifo_full;
    assign pcm_fs       = pcm_fs_q;
    assign pcm_l        = pcm_l_q;
    assign pcm_r        = pcm_r_q;
    assign underrun_cnt = under_q;
    assign overflow_cnt = over_q;

endmodule

// File: tb/tb_hdmi_audio_scheduler.sv
// Scoreboard bench for hdmi_audio_scheduler: accepted frames are queued at drive time and
// compared against pcm_l/pcm_r at every predicted sample slot.
module tb_hdmi_audio_scheduler;

    logic        pixel_clk = 1'b0;
    logic        sys_reset_125 = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_left = '0;
    logic [15:0] in_right = '0;
    logic        mute = 1'b0;
    logic        pcm_fs;
    logic [23:0] pcm_l, pcm_r;
    logic [3:0]  fifo_level;
    logic [15:0] underrun_cnt, overflow_cnt;

    hdmi_audio_scheduler dut (
        .pixel_clk     (pixel_clk),
        .sys_reset_125 (sys_reset_125),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_left       (in_left),
        .in_right      (in_right),
        .mute          (mute),
        .pcm_fs        (pcm_fs),
        .pcm_l         (pcm_l),
        .pcm_r         (pcm_r),
        .fifo_level    (fifo_level),
        .underrun_cnt  (underrun_cnt),
        .overflow_cnt  (overflow_cnt)
    );

    always #20 pixel_clk = ~pixel_clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    longint      e = 0;            // posedges since reset release
    logic [31:0] exp_q[$];         // accepted {left, right} frames awaiting output
    bit          m_run = 0;
    int          exp_under = 0;
    int          exp_ovf = 0;
    logic [23:0] exp_l = '0;
    logic [23:0] exp_r = '0;
    logic        fs_prev = 1'b0;
    int          n_tog = 0;
    int          snap[4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Ticks seen up to edge k: the phase has advanced 8*(k-1) units against a 3125 modulus.
    function automatic longint n_ticks(input longint k);
        return (8 * (k - 1)) / 3125;
    endfunction

    function automatic bit is_tick(input longint k);
        if (k < 2) return 1'b0;
        return n_ticks(k) != n_ticks(k - 1);
    endfunction

    function automatic bit is_slot(input longint k);
        return is_tick(k) && (n_ticks(k) % 2 == 0);
    endfunction

    function automatic logic [23:0] fmt(input logic [15:0] s);
        int v;
        v = int'($signed(s)) * 32;
        return v[23:0];
    endfunction

    task automatic step();
        bit          tk, sl, pop, acc;
        int          lvl;
        logic [31:0] fr;
        e++;
        tk  = is_tick(e);
        sl  = is_slot(e);
        lvl = exp_q.size();
        pop = 1'b0;
        if (sl) begin
            if (m_run) begin
                if (lvl > 0) begin
                    pop = 1'b1;
                end else begin
                    m_run = 1'b0;
                    if (mute) begin
                        exp_l = '0;
                        exp_r = '0;
                    end else if (exp_under != 16'hFFFF) begin
                        exp_under++;
                    end
                end
            end else if (lvl >= 4) begin
                pop   = 1'b1;
                m_run = 1'b1;
            end else begin
                exp_l = '0;
                exp_r = '0;
            end
        end
        acc = in_valid && (lvl < 8 || pop);
        if (in_valid && !acc && exp_ovf != 16'hFFFF) exp_ovf++;
        if (pop) begin
            fr    = exp_q.pop_front();
            exp_l = mute ? 24'h0 : fmt(fr[31:16]);
            exp_r = mute ? 24'h0 : fmt(fr[15:0]);
        end
        if (acc) exp_q.push_back({in_left, in_right});
        @(posedge pixel_clk);
        @(negedge pixel_clk);
        if (pcm_fs !== fs_prev) n_tog++;
        fs_prev = pcm_fs;
        if (tk || is_tick(e + 1)) chk("pcm_fs", pcm_fs, 32'(n_ticks(e) % 2));
        if (sl) begin
            chk("slot_pcm_l", pcm_l, exp_l);
            chk("slot_pcm_r", pcm_r, exp_r);
            chk("slot_level", fifo_level, exp_q.size());
            chk("slot_in_ready", in_ready, exp_q.size() < 8);
        end
    endtask

    task automatic run_slots(input int n);
        int seen = 0;
        int guard = 0;
        while (seen < n && guard < n * 800 + 10) begin
            step();
            guard++;
            if (is_slot(e)) seen++;
        end
        if (seen < n) chk("slot_timeout", seen, n);
    endtask

    task automatic advance_to_slot();
        int guard = 0;
        while (!is_slot(e + 1) && guard < 900) begin
            step();
            guard++;
        end
    endtask

    // Steps until the next n edges are free of sample slots.
    task automatic wait_clear(input int n);
        bit busy;
        int guard = 0;
        do begin
            busy = 1'b0;
            for (int k = 1; k <= n; k++) if (is_slot(e + k)) busy = 1'b1;
            if (busy) begin
                step();
                guard++;
            end
        end while (busy && guard < 900);
    endtask

    task automatic push_burst(input int n, input logic [15:0] l0, input logic [15:0] r0);
        wait_clear(n + 1);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_left  = l0 + 16'(i);
            in_right = r0 + 16'(i);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge pixel_clk);
        sys_reset_125 = 1'b1;
        in_valid      = 1'b0;
        mute          = 1'b0;
        #1;
        chk("rst_pcm_fs", pcm_fs, 0);
        chk("rst_pcm_l", pcm_l, 0);
        chk("rst_pcm_r", pcm_r, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_underrun", underrun_cnt, 0);
        chk("rst_overflow", overflow_cnt, 0);
        repeat (3) @(negedge pixel_clk);
        sys_reset_125 = 1'b0;
        exp_q.delete();
        m_run     = 1'b0;
        exp_under = 0;
        exp_ovf   = 0;
        exp_l     = '0;
        exp_r     = '0;
        e         = 0;
        fs_prev   = 1'b0;
    endtask

    initial begin
        do_reset();

        // Idle priming: pcm_fs cadence and silent output.
        for (int i = 0; i < 10000; i++) begin
            step();
            if (e == 1)    snap[0] = n_tog;
            if (e == 3126) snap[1] = n_tog;
            if (e == 6251) snap[2] = n_tog;
            if (e == 9376) snap[3] = n_tog;
        end
        chk("t1_toggles_w0", snap[1] - snap[0], 8);
        chk("t1_toggles_w1", snap[2] - snap[1], 8);
        chk("t1_toggles_w2", snap[3] - snap[2], 8);
        chk("t1_underrun", underrun_cnt, 0);
        chk("t1_pcm_l", pcm_l, 0);

        // Four frames, then starvation.
        push_burst(4, 16'h1234, 16'hFEDC);
        run_slots(1);
        chk("t2_first_l", pcm_l, 24'h024680);
        chk("t2_first_r", pcm_r, 24'hFFDB80);
        run_slots(3);
        run_slots(1);
        chk("t2_underrun", underrun_cnt, 1);
        chk("t2_hold_l", pcm_l, 24'h0246E0);
        chk("t2_hold_r", pcm_r, 24'hFFDBE0);

        // Overfill with no slot in between.
        push_burst(10, 16'h0100, 16'h8000);
        chk("t3_in_ready", in_ready, 0);
        chk("t3_level", fifo_level, 8);
        chk("t3_overflow", overflow_cnt, 2);
        chk("t3_overflow_model", overflow_cnt, exp_ovf);

        // Push on the exact slot cycle while full.
        advance_to_slot();
        in_valid = 1'b1;
        in_left  = 16'h7FFF;
        in_right = 16'h8001;
        step();
        in_valid = 1'b0;
        chk("t4_level", fifo_level, 8);
        chk("t4_overflow", overflow_cnt, 2);
        chk("t4_first_l", pcm_l, 24'h002000);
        chk("t4_first_r", pcm_r, 24'hF00000);
        run_slots(8);
        chk("t4_late_l", pcm_l, 24'h0FFFE0);
        chk("t4_late_r", pcm_r, 24'hF00020);

        // Mute in RUN with a full FIFO keeps popping.
        push_burst(8, 16'h4000, 16'hC000);
        chk("t5_full_level", fifo_level, 8);
        mute = 1'b1;
        run_slots(2);
        chk("t5_mute_l", pcm_l, 0);
        chk("t5_mute_r", pcm_r, 0);
        chk("t5_mute_level", fifo_level, 6);
        mute = 1'b0;
        run_slots(1);
        chk("t5_unmute_l", pcm_l, 24'h080040);
        chk("t5_level", fifo_level, 5);

        // Reset mid-RUN, then re-prime.
        do_reset();
        push_burst(3, 16'h0A00, 16'h0B00);
        run_slots(2);
        chk("t6_level", fifo_level, 3);
        chk("t6_silent_l", pcm_l, 0);
        push_burst(1, 16'h0A03, 16'h0B03);
        run_slots(1);
        chk("t6_reprime_l", pcm_l, 24'h014000);
        chk("t6_reprime_r", pcm_r, 24'h016000);

        // Muted starvation is not an underrun.
        mute = 1'b1;
        run_slots(4);
        chk("t7_underrun", underrun_cnt, 0);
        chk("t7_level", fifo_level, 0);
        chk("t7_pcm_l", pcm_l, 0);
        mute = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
